// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame buffer controller: back-buffer write steering and front-buffer scan.
// Optional macro FB_DROP_CNT_EN enables the saturating dropped-frame counter.
module fb_pingpong_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int FRAME_WORDS = 307200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              WE0,
  output logic              WE1,
  output logic [ADDR_W-1:0] addr_w,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] addr_r,
  output logic              rd_sel,
  output logic              frame_start,
  output logic              sof_err,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DONE
  } wstate_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FRAME_WORDS - 1);

  wstate_t           state;
  wstate_t           state_nx;
  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] wcnt_nx;
  logic              err_nx;
  logic              sof_px;
  logic              restart;
  logic              wr_hit;
  logic              wrap;
  logic              swap;

  assign sof_px  = in_valid & in_sof;
  assign wrap    = rd_en & (addr_r == LAST);
  assign swap    = wrap & (state == W_DONE);
  assign restart = sof_px & (state == W_FILL);

  // Gated by reset so no buffer is written while reset is held.
  assign wr_hit = reset & in_valid &
                  (((state == W_IDLE) & in_sof) |
                   (state == W_FILL));

  assign WE0 = wr_hit & rd_sel;
  assign WE1 = wr_hit & ~rd_sel;

  // A mid-frame restart pixel lands at word 0, not at the counter.
  assign addr_w = restart ? '0 : wcnt;

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    err_nx   = sof_err;
    case (state)
      W_IDLE: begin
        if (sof_px) begin
          state_nx = W_FILL;
          wcnt_nx  = ADDR_W'(1);
        end
      end
      W_FILL: begin
        if (restart) begin
          wcnt_nx = ADDR_W'(1);
          err_nx  = 1'b1;
        end else if (in_valid) begin
          if (wcnt == LAST) begin
            wcnt_nx  = '0;
            state_nx = W_DONE;
          end else begin
            wcnt_nx = wcnt + 1'b1;
          end
        end
      end
      W_DONE: begin
        if (swap) state_nx = W_IDLE;
      end
      default: state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= W_IDLE;
      wcnt    <= '0;
      sof_err <= 1'b0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      sof_err <= err_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_r      <= '0;
      rd_sel      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      rd_sel      <= rd_sel ^ swap;
      if (rd_en) begin
        addr_r <= wrap ? '0 : addr_r + 1'b1;
      end
    end
  end

`ifdef FB_DROP_CNT_EN
  logic       drop_ev;
  logic [7:0] drop_q;

  assign drop_ev  = sof_px & (state == W_DONE);
  assign drop_cnt = drop_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_q <= 8'd0;
    end else if (drop_ev && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end
`else
  assign drop_cnt = 8'd0;
`endif

endmodule
